// File: rtl/coriolis_ctrl_pkg.sv
// Shared state encoding and default sizing for the coriolis stream controller.
package coriolis_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    localparam int DEF_STREAMW      = 32;
    localparam int DEF_CNTW         = 16;
    localparam int DEF_MAX_INFLIGHT = 8;

endpackage

// File: rtl/coriolis_credit_cnt.sv
// Up/down in-flight element counter: saturates at 0 and MAX_INFLIGHT, raises full at the cap.
module coriolis_credit_cnt
    import coriolis_ctrl_pkg::*;
#(
    parameter int CNTW         = DEF_CNTW,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic            dec,
    output logic [CNTW-1:0] count,
    output logic            full
);

    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_INFLIGHT);

    assign full = (count >= MAX_CNT);

    // inc and dec together leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(dec && (count == '0)));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (count <= MAX_CNT));

endmodule

// File: rtl/coriolis_stream_ctrl.sv
// Run-level controller: issues N u/v pairs into the coriolis kernel under a credit limit
// and forwards un/vn results to the sink, pulsing done after the last result.
module coriolis_stream_ctrl
    import coriolis_ctrl_pkg::*;
#(
    parameter int STREAMW      = DEF_STREAMW,
    parameter int CNTW         = DEF_CNTW,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNTW-1:0]    n_items,
    output logic               busy,
    output logic               done,
    output logic [CNTW-1:0]    in_count,
    output logic [CNTW-1:0]    out_count,
    input  logic               src_valid,
    input  logic [STREAMW-1:0] src_u,
    input  logic [STREAMW-1:0] src_v,
    output logic               src_ready,
    output logic [STREAMW-1:0] k_u,
    output logic [STREAMW-1:0] k_v,
    output logic               k_ivalid_u,
    output logic               k_ivalid_v,
    input  logic               k_iready,
    input  logic [STREAMW-1:0] k_un,
    input  logic [STREAMW-1:0] k_vn,
    input  logic               k_ovalid,
    output logic               k_oready_un,
    output logic               k_oready_vn,
    output logic [STREAMW-1:0] snk_un,
    output logic [STREAMW-1:0] snk_vn,
    output logic               snk_valid,
    input  logic               snk_ready,
    output ctrl_state_e        dbg_state,
    output logic [CNTW-1:0]    dbg_inflight,
    output logic [CNTW-1:0]    dbg_n_reg
);

    ctrl_state_e     state, next_state;
    logic [CNTW-1:0] n_reg;
    logic [CNTW-1:0] inflight;
    logic            credit_full;
    logic            job_start;
    logic            run_st;
    logic            active_st;
    logic            in_room;
    logic            in_last;
    logic            out_last;
    logic            offer;
    logic            issue;
    logic            deliver;

    assign job_start = (state == IDLE) && start;
    assign run_st    = (state == RUN);
    assign active_st = (state == RUN) || (state == DRAIN);

    assign in_room  = (in_count < n_reg);
    assign in_last  = (in_count == (n_reg - 1'b1));
    assign out_last = (out_count == (n_reg - 1'b1));

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    // valid never depends on ready; src_ready is the kernel-side transfer itself, so
    // source and kernel see the same beat and the controller adds no latency.
    assign offer   = run_st && src_valid && in_room && !credit_full;
    assign issue   = offer && k_iready;
    assign deliver = active_st && k_ovalid && snk_ready;

    assign k_u        = src_u;
    assign k_v        = src_v;
    assign k_ivalid_u = offer;
    assign k_ivalid_v = offer;
    assign src_ready  = issue;

    assign k_oready_un = active_st && snk_ready;
    assign k_oready_vn = active_st && snk_ready;
    assign snk_valid   = active_st && k_ovalid;
    assign snk_un      = k_un;
    assign snk_vn      = k_vn;

    assign busy = active_st;
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (n_items == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue && in_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (deliver && out_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counts hold after DONE so software can read them until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg     <= '0;
            in_count  <= '0;
            out_count <= '0;
        end else if (job_start) begin
            n_reg     <= n_items;
            in_count  <= '0;
            out_count <= '0;
        end else begin
            if (issue) begin
                in_count <= in_count + 1'b1;
            end
            if (deliver) begin
                out_count <= out_count + 1'b1;
            end
        end
    end

    coriolis_credit_cnt #(
        .CNTW         (CNTW),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .clr   (job_start),
        .inc   (issue),
        .dec   (deliver),
        .count (inflight),
        .full  (credit_full)
    );

    assign dbg_state    = state;
    assign dbg_inflight = inflight;
    assign dbg_n_reg    = n_reg;

endmodule

// File: tb/tb_coriolis_stream_ctrl.sv
// Bench for coriolis_stream_ctrl: two instances (credit limit 8 and 2), each fed by a
// 3-stage stallable kernel model; results are checked against a queue of expected pairs.
module tb_coriolis_stream_ctrl;
    import coriolis_ctrl_pkg::*;

    localparam int SW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start [2];
    logic [CW-1:0] n_items [2];
    logic          busy [2];
    logic          done [2];
    logic [CW-1:0] in_count [2];
    logic [CW-1:0] out_count [2];
    logic          src_valid [2];
    logic [SW-1:0] src_u [2];
    logic [SW-1:0] src_v [2];
    logic          src_ready [2];
    logic [SW-1:0] k_u [2];
    logic [SW-1:0] k_v [2];
    logic          k_ivalid_u [2];
    logic          k_ivalid_v [2];
    logic          k_iready [2];
    logic [SW-1:0] k_un [2];
    logic [SW-1:0] k_vn [2];
    logic          k_ovalid [2];
    logic          k_oready_un [2];
    logic          k_oready_vn [2];
    logic [SW-1:0] snk_un [2];
    logic [SW-1:0] snk_vn [2];
    logic          snk_valid [2];
    logic          snk_ready [2];
    ctrl_state_e   dbg_state [2];
    logic [CW-1:0] dbg_inflight [2];
    logic [CW-1:0] dbg_n_reg [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        coriolis_stream_ctrl #(
            .STREAMW      (SW),
            .CNTW         (CW),
            .MAX_INFLIGHT ((g == 0) ? 8 : 2)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start[g]),
            .n_items      (n_items[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .in_count     (in_count[g]),
            .out_count    (out_count[g]),
            .src_valid    (src_valid[g]),
            .src_u        (src_u[g]),
            .src_v        (src_v[g]),
            .src_ready    (src_ready[g]),
            .k_u          (k_u[g]),
            .k_v          (k_v[g]),
            .k_ivalid_u   (k_ivalid_u[g]),
            .k_ivalid_v   (k_ivalid_v[g]),
            .k_iready     (k_iready[g]),
            .k_un         (k_un[g]),
            .k_vn         (k_vn[g]),
            .k_ovalid     (k_ovalid[g]),
            .k_oready_un  (k_oready_un[g]),
            .k_oready_vn  (k_oready_vn[g]),
            .snk_un       (snk_un[g]),
            .snk_vn       (snk_vn[g]),
            .snk_valid    (snk_valid[g]),
            .snk_ready    (snk_ready[g]),
            .dbg_state    (dbg_state[g]),
            .dbg_inflight (dbg_inflight[g]),
            .dbg_n_reg    (dbg_n_reg[g])
        );
    end

    // Kernel model: un = u + v, vn = u - v, three stages, whole pipe stalls on output backpressure.
    logic          kv [2][3];
    logic [SW-1:0] kun [2][3];
    logic [SW-1:0] kvn [2][3];

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            k_ovalid[d] = kv[d][2];
            k_un[d]     = kun[d][2];
            k_vn[d]     = kvn[d][2];
            k_iready[d] = !(kv[d][2] && !(k_oready_un[d] && k_oready_vn[d]));
        end
    end

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                for (int s = 0; s < 3; s++) kv[d][s] <= 1'b0;
            end else if (k_iready[d]) begin
                kv[d][0]  <= k_ivalid_u[d] & k_ivalid_v[d];
                kun[d][0] <= k_u[d] + k_v[d];
                kvn[d][0] <= k_u[d] - k_v[d];
                for (int s = 1; s < 3; s++) begin
                    kv[d][s]  <= kv[d][s-1];
                    kun[d][s] <= kun[d][s-1];
                    kvn[d][s] <= kvn[d][s-1];
                end
            end
        end
    end

    // Scoreboard and per-job statistics
    logic [2*SW-1:0] exp_q[$];
    int n_checks;
    int n_fail;
    int issue_cnt [2];
    int deliver_cnt [2];
    int first_iss [2];
    int last_iss [2];
    int last_del [2];
    int done_cyc [2];
    int done_cnt [2];
    int busy_cnt [2];
    int start_cyc [2];
    int both_cnt [2];
    int inf_mis [2];
    int bad_issue [2];
    int model_inf [2];

    task automatic clear_sb();
        exp_q.delete();
        for (int d = 0; d < 2; d++) begin
            issue_cnt[d] = 0; deliver_cnt[d] = 0; first_iss[d] = -1; last_iss[d] = -1;
            last_del[d] = -1; done_cyc[d] = -1; done_cnt[d] = 0; busy_cnt[d] = 0;
            start_cyc[d] = -1; both_cnt[d] = 0; inf_mis[d] = 0; bad_issue[d] = 0;
        end
    endtask

    initial begin
        bit iss;
        bit del;
        logic [2*SW-1:0] exp;
        for (int d = 0; d < 2; d++) model_inf[d] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    model_inf[d] = 0;
                end else begin
                    if (dbg_inflight[d] !== CW'(model_inf[d])) inf_mis[d]++;
                    iss = src_ready[d];
                    del = snk_valid[d] && snk_ready[d];
                    if (iss && !src_valid[d]) bad_issue[d]++;
                    if (busy[d]) busy_cnt[d]++;
                    if (done[d]) begin done_cnt[d]++; done_cyc[d] = cyc; end
                    if (start[d] && start_cyc[d] < 0) start_cyc[d] = cyc;
                    if (iss && del) both_cnt[d]++;
                    if (del) begin
                        deliver_cnt[d]++;
                        last_del[d] = cyc;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_underflow dut%0d: got un/vn %h with nothing expected", d, {snk_un[d], snk_vn[d]});
                        end else begin
                            exp = exp_q.pop_front();
                            if ({snk_un[d], snk_vn[d]} !== exp) begin
                                n_fail++;
                                $display("FAIL sb_data dut%0d: got un/vn %h want %h", d, {snk_un[d], snk_vn[d]}, exp);
                            end
                        end
                    end
                    if (iss) begin
                        issue_cnt[d]++;
                        if (first_iss[d] < 0) first_iss[d] = cyc;
                        last_iss[d] = cyc;
                        exp_q.push_back({src_u[d] + src_v[d], src_u[d] - src_v[d]});
                    end
                    if (iss && !del) model_inf[d]++;
                    else if (del && !iss && model_inf[d] > 0) model_inf[d]--;
                end
            end
        end
    end

    // Driver: starts a job and runs it to done; optional source toggling, sink stall,
    // mid-job start pulse and a single-cycle probe of internal state.
    task automatic run_job(input int d, input int n, input bit toggle, input int stall,
                           input int restart_at, input int probe_at, output bit ok,
                           output bit p_sr, output logic [CW-1:0] p_inf,
                           output logic [CW-1:0] p_nreg, output logic [CW-1:0] p_in);
        int c;
        bit took;
        ok = 1'b0; c = 0; p_sr = 1'b0; p_inf = '0; p_nreg = '0; p_in = '0;
        src_u[d] = $urandom; src_v[d] = $urandom;
        src_valid[d] = 1'b1;
        snk_ready[d] = (stall == 0);
        start[d] = 1'b1;
        n_items[d] = CW'(n);
        while (!ok && c < 400) begin
            @(negedge clk);
            took = src_ready[d];
            if (done[d]) ok = 1'b1;
            if (c == probe_at) begin
                p_sr = took; p_inf = dbg_inflight[d]; p_nreg = dbg_n_reg[d]; p_in = in_count[d];
            end
            @(posedge clk); #1;
            c++;
            start[d] = (c == restart_at);
            if (c == restart_at) n_items[d] = CW'(n + 7);
            if (took) begin src_u[d] = $urandom; src_v[d] = $urandom; end
            if (toggle) src_valid[d] = ~src_valid[d];
            snk_ready[d] = (c >= stall);
        end
        src_valid[d] = 1'b0;
        snk_ready[d] = 1'b1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL job_timeout dut%0d: done not seen after %0d cycles", d, c); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
        n_checks++; if (done[0] !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done[0]); end
        n_checks++; if (src_ready[0] !== 1'b0) begin n_fail++; $display("FAIL rst_src_ready: got %b want 0", src_ready[0]); end
        n_checks++; if (k_ivalid_u[0] !== 1'b0 || k_ivalid_v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_ivalid: got %b%b want 00", k_ivalid_u[0], k_ivalid_v[0]); end
        n_checks++; if (k_oready_un[0] !== 1'b0 || k_oready_vn[0] !== 1'b0) begin n_fail++; $display("FAIL rst_oready: got %b%b want 00", k_oready_un[0], k_oready_vn[0]); end
        n_checks++; if (snk_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_snk_valid: got %b want 0", snk_valid[0]); end
        n_checks++; if (in_count[0] !== '0 || out_count[0] !== '0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d want 0/0", in_count[0], out_count[0]); end
        n_checks++; if (dbg_state[0] !== IDLE || dbg_state[1] !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d/%0d want IDLE", dbg_state[0], dbg_state[1]); end
        n_checks++; if (dbg_inflight[0] !== '0 || dbg_n_reg[0] !== '0) begin n_fail++; $display("FAIL rst_credit_nreg: got %0d/%0d want 0/0", dbg_inflight[0], dbg_n_reg[0]); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int c;
        bit ok, p_sr;
        logic [CW-1:0] p_inf, p_nreg, p_in;
        clear_sb();
        src_u[0] = $urandom; src_v[0] = $urandom;
        src_valid[0] = 1'b1; snk_ready[0] = 1'b1;
        start[0] = 1'b1; n_items[0] = 16'd8;
        @(posedge clk); #1;
        start[0] = 1'b0;
        c = 0;
        while (issue_cnt[0] < 3 && c < 50) begin @(posedge clk); #1; c++; end
        n_checks++; if (issue_cnt[0] < 3) begin n_fail++; $display("FAIL midrst_timeout: got %0d issues want 3", issue_cnt[0]); end
        rst = 1'b0;
        #1;
        n_checks++; if (busy[0] !== 1'b0 || src_ready[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_ready: got %b%b want 00", busy[0], src_ready[0]); end
        n_checks++; if (k_ivalid_u[0] !== 1'b0 || snk_valid[0] !== 1'b0 || k_oready_un[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_handshake: got %b%b%b want 000", k_ivalid_u[0], snk_valid[0], k_oready_un[0]); end
        n_checks++; if (in_count[0] !== '0 || dbg_inflight[0] !== '0) begin n_fail++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", in_count[0], dbg_inflight[0]); end
        n_checks++; if (dbg_state[0] !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want IDLE", dbg_state[0]); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_sb();
        run_job(0, 3, 1'b0, 0, -1, -1, ok, p_sr, p_inf, p_nreg, p_in);
        n_checks++; if (in_count[0] !== 16'd3 || out_count[0] !== 16'd3) begin n_fail++; $display("FAIL midrst_rerun_counts: got %0d/%0d want 3/3", in_count[0], out_count[0]); end
        n_checks++; if (exp_q.size() != 0 || deliver_cnt[0] != 3) begin n_fail++; $display("FAIL midrst_rerun_sb: got %0d left, %0d delivered want 0, 3", exp_q.size(), deliver_cnt[0]); end
    endtask

    task automatic test_basic();
        bit ok, p_sr;
        logic [CW-1:0] p_inf, p_nreg, p_in;
        clear_sb();
        run_job(0, 4, 1'b0, 0, -1, -1, ok, p_sr, p_inf, p_nreg, p_in);
        n_checks++; if (issue_cnt[0] != 4 || last_iss[0] - first_iss[0] != 3) begin n_fail++; $display("FAIL basic_issue: got %0d issues over %0d cycles want 4 over 3", issue_cnt[0], last_iss[0] - first_iss[0]); end
        n_checks++; if (deliver_cnt[0] != 4 || exp_q.size() != 0) begin n_fail++; $display("FAIL basic_deliver: got %0d delivered, %0d left want 4, 0", deliver_cnt[0], exp_q.size()); end
        n_checks++; if (done_cyc[0] != last_del[0] + 1 || done_cnt[0] != 1) begin n_fail++; $display("FAIL basic_done_timing: got cycle %0d (%0d pulses) want %0d (1)", done_cyc[0], done_cnt[0], last_del[0] + 1); end
        n_checks++; if (in_count[0] !== 16'd4 || out_count[0] !== 16'd4) begin n_fail++; $display("FAIL basic_counts: got %0d/%0d want 4/4", in_count[0], out_count[0]); end
        n_checks++; if (dbg_state[0] !== IDLE || busy[0] !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got state %0d busy %b want IDLE 0", dbg_state[0], busy[0]); end
    endtask

    task automatic test_zero();
        bit ok, p_sr;
        logic [CW-1:0] p_inf, p_nreg, p_in;
        clear_sb();
        run_job(0, 0, 1'b0, 0, -1, -1, ok, p_sr, p_inf, p_nreg, p_in);
        n_checks++; if (issue_cnt[0] != 0) begin n_fail++; $display("FAIL zero_issue: got %0d issues want 0", issue_cnt[0]); end
        n_checks++; if (done_cyc[0] != start_cyc[0] + 1 || done_cnt[0] != 1) begin n_fail++; $display("FAIL zero_done: got cycle %0d (%0d pulses) want %0d (1)", done_cyc[0], done_cnt[0], start_cyc[0] + 1); end
        n_checks++; if (busy_cnt[0] != 0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt[0]); end
        n_checks++; if (in_count[0] !== '0 || out_count[0] !== '0) begin n_fail++; $display("FAIL zero_counts: got %0d/%0d want 0/0", in_count[0], out_count[0]); end
    endtask

    task automatic test_backpressure();
        bit ok, p_sr;
        logic [CW-1:0] p_inf, p_nreg, p_in;
        clear_sb();
        run_job(1, 6, 1'b0, 10, -1, 8, ok, p_sr, p_inf, p_nreg, p_in);
        n_checks++; if (p_sr !== 1'b0 || p_in !== 16'd2) begin n_fail++; $display("FAIL bp_stall_issue: got src_ready %b in_count %0d want 0, 2", p_sr, p_in); end
        n_checks++; if (p_inf !== 16'd2) begin n_fail++; $display("FAIL bp_inflight: got %0d want 2", p_inf); end
        n_checks++; if (inf_mis[1] != 0) begin n_fail++; $display("FAIL bp_credit_track: got %0d mismatching cycles want 0", inf_mis[1]); end
        n_checks++; if (in_count[1] !== 16'd6 || out_count[1] !== 16'd6) begin n_fail++; $display("FAIL bp_counts: got %0d/%0d want 6/6", in_count[1], out_count[1]); end
        n_checks++; if (deliver_cnt[1] != 6 || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_deliver: got %0d delivered, %0d left want 6, 0", deliver_cnt[1], exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok, p_sr;
        logic [CW-1:0] p_inf, p_nreg, p_in;
        clear_sb();
        run_job(0, 20, 1'b0, 0, 6, 10, ok, p_sr, p_inf, p_nreg, p_in);
        n_checks++; if (p_nreg !== 16'd20) begin n_fail++; $display("FAIL b2b_nreg: got %0d want 20", p_nreg); end
        n_checks++; if (p_inf !== 16'd3 || p_sr !== 1'b1) begin n_fail++; $display("FAIL b2b_steady: got inflight %0d src_ready %b want 3, 1", p_inf, p_sr); end
        n_checks++; if (both_cnt[0] != 17 || inf_mis[0] != 0) begin n_fail++; $display("FAIL b2b_overlap: got %0d overlap cycles, %0d credit mismatches want 17, 0", both_cnt[0], inf_mis[0]); end
        n_checks++; if (in_count[0] !== 16'd20 || out_count[0] !== 16'd20 || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_counts: got %0d/%0d, %0d left want 20/20, 0", in_count[0], out_count[0], exp_q.size()); end
    endtask

    task automatic test_toggle();
        bit ok, p_sr;
        logic [CW-1:0] p_inf, p_nreg, p_in;
        clear_sb();
        run_job(0, 5, 1'b1, 0, -1, -1, ok, p_sr, p_inf, p_nreg, p_in);
        n_checks++; if (issue_cnt[0] != 5 || bad_issue[0] != 0) begin n_fail++; $display("FAIL toggle_issue: got %0d issues, %0d without valid want 5, 0", issue_cnt[0], bad_issue[0]); end
        n_checks++; if (in_count[0] !== 16'd5 || out_count[0] !== 16'd5) begin n_fail++; $display("FAIL toggle_counts: got %0d/%0d want 5/5", in_count[0], out_count[0]); end
        n_checks++; if (exp_q.size() != 0 || done_cnt[0] != 1) begin n_fail++; $display("FAIL toggle_end: got %0d left, %0d done pulses want 0, 1", exp_q.size(), done_cnt[0]); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; n_items[d] = '0; src_valid[d] = 1'b0;
            src_u[d] = '0; src_v[d] = '0; snk_ready[d] = 1'b1;
        end
        clear_sb();
        test_reset();
        test_reset_mid_run();
        test_basic();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_toggle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
